// File: rtl/spi_arb.sv
// spi_arb: round-robin arbiter giving the inertial and A2D interfaces shared
// use of a single SPI master. Only one transaction is in flight at a time.
// The command word is captured at grant and launched with a one-cycle strobe.
// A bounded wait for spi_done aborts a stuck transaction.
//
// Ports
//   clk, rst                clock, asynchronous active-high reset
//   req_inert, cmd_inert    inertial request level and command word
//   req_a2d, cmd_a2d        A2D request level and command word
//   spi_wrt, spi_cmd        launch strobe and command word to the SPI master
//   spi_done, spi_rd        completion pulse and read data from the SPI master
//   gnt_inert, gnt_a2d      grant levels, high from capture through FINISH
//   done_inert, done_a2d    one-cycle completion pulses to the owner
//   rd_data                 read data from the last completed transaction
//   timeout                 one-cycle pulse when a transaction is aborted
//
// state  | meaning
// IDLE   | no owner; arbitrate pending requests
// LAUNCH | spi_wrt strobe issued with the captured command
// WAIT   | waiting for spi_done, counting toward the abort limit
// FINISH | owner's done pulse; round-robin pointer moves to the owner
module spi_arb #(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_inert,
  input  logic [15:0] cmd_inert,
  input  logic        req_a2d,
  input  logic [15:0] cmd_a2d,
  output logic        spi_wrt,
  output logic [15:0] spi_cmd,
  input  logic        spi_done,
  input  logic [15:0] spi_rd,
  output logic        gnt_inert,
  output logic        gnt_a2d,
  output logic        done_inert,
  output logic        done_a2d,
  output logic [15:0] rd_data,
  output logic        timeout
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, FINISH} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_a2d_q, last_a2d_d;   // 1: A2D was served most recently
  logic          owner_a2d_q, owner_a2d_d;
  logic          spi_wrt_q, spi_wrt_d;
  logic [15:0]   spi_cmd_q, spi_cmd_d;
  logic          gnt_inert_q, gnt_inert_d;
  logic          gnt_a2d_q, gnt_a2d_d;
  logic          done_inert_q, done_inert_d;
  logic          done_a2d_q, done_a2d_d;
  logic [15:0]   rd_data_q, rd_data_d;
  logic          limit_hit;

  // Abort must be known in the same cycle as spi_done so that a completion
  // arriving on the last allowed cycle wins; hence this pulse is decoded
  // from registered state and the live spi_done rather than registered.
  assign limit_hit = (state_q == WAIT) && (cnt_q == CNT_LAST);
  assign timeout   = limit_hit && !spi_done;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_a2d_d   = last_a2d_q;
    owner_a2d_d  = owner_a2d_q;
    spi_wrt_d    = 1'b0;
    spi_cmd_d    = spi_cmd_q;
    gnt_inert_d  = gnt_inert_q;
    gnt_a2d_d    = gnt_a2d_q;
    done_inert_d = 1'b0;
    done_a2d_d   = 1'b0;
    rd_data_d    = rd_data_q;
    case (state_q)
      IDLE: begin
        if (req_inert && (!req_a2d || last_a2d_q)) begin
          owner_a2d_d = 1'b0;
          gnt_inert_d = 1'b1;
          spi_cmd_d   = cmd_inert;
          spi_wrt_d   = 1'b1;
          state_d     = LAUNCH;
        end else if (req_a2d) begin
          owner_a2d_d = 1'b1;
          gnt_a2d_d   = 1'b1;
          spi_cmd_d   = cmd_a2d;
          spi_wrt_d   = 1'b1;
          state_d     = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (spi_done || limit_hit) begin
          if (spi_done) rd_data_d = spi_rd;
          done_inert_d = !owner_a2d_q;
          done_a2d_d   = owner_a2d_q;
          state_d      = FINISH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FINISH: begin
        last_a2d_d  = owner_a2d_q;
        gnt_inert_d = 1'b0;
        gnt_a2d_d   = 1'b0;
        spi_cmd_d   = 16'h0000;
        state_d     = IDLE;
      end
      default: begin
        gnt_inert_d = 1'b0;
        gnt_a2d_d   = 1'b0;
        spi_cmd_d   = 16'h0000;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_a2d_q   <= 1'b1;
      owner_a2d_q  <= 1'b0;
      spi_wrt_q    <= 1'b0;
      spi_cmd_q    <= 16'h0000;
      gnt_inert_q  <= 1'b0;
      gnt_a2d_q    <= 1'b0;
      done_inert_q <= 1'b0;
      done_a2d_q   <= 1'b0;
      rd_data_q    <= 16'h0000;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_a2d_q   <= last_a2d_d;
      owner_a2d_q  <= owner_a2d_d;
      spi_wrt_q    <= spi_wrt_d;
      spi_cmd_q    <= spi_cmd_d;
      gnt_inert_q  <= gnt_inert_d;
      gnt_a2d_q    <= gnt_a2d_d;
      done_inert_q <= done_inert_d;
      done_a2d_q   <= done_a2d_d;
      rd_data_q    <= rd_data_d;
    end
  end

  assign spi_wrt    = spi_wrt_q;
  assign spi_cmd    = spi_cmd_q;
  assign gnt_inert  = gnt_inert_q;
  assign gnt_a2d    = gnt_a2d_q;
  assign done_inert = done_inert_q;
  assign done_a2d   = done_a2d_q;
  assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_spi_arb.sv
// Testbench for spi_arb with TIMEOUT_CYC=8. Expectations come from a
// transaction-level model: who wins, which word launches, when done arrives,
// and what read data results.
module tb_spi_arb;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_inert, req_a2d, spi_done;
  logic [15:0] cmd_inert, cmd_a2d, spi_rd;
  logic        spi_wrt, gnt_inert, gnt_a2d, done_inert, done_a2d, timeout;
  logic [15:0] spi_cmd, rd_data;

  int compared = 0;
  int mismatched = 0;
  bit last_a2d = 1'b1;
  logic [15:0] model_rd = 16'h0000;

  spi_arb #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .req_inert(req_inert), .cmd_inert(cmd_inert),
    .req_a2d(req_a2d), .cmd_a2d(cmd_a2d),
    .spi_wrt(spi_wrt), .spi_cmd(spi_cmd),
    .spi_done(spi_done), .spi_rd(spi_rd),
    .gnt_inert(gnt_inert), .gnt_a2d(gnt_a2d),
    .done_inert(done_inert), .done_a2d(done_a2d),
    .rd_data(rd_data), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit gi; bit ga; bit wrt0; logic [15:0] cmd0;
    int wrt_extra; int cmd_bad; int to_cyc; int to_count; int done_cyc; int multi;
    bit di; bit da; bit gnt_done; logic [15:0] rd; bit idle_ok;
  } obs_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one transaction from IDLE and records what the DUT did. done_at is
  // the WAIT-cycle index (0 = first WAIT cycle) at which spi_done is driven;
  // a value >= TO means the master never answers.
  task automatic drive_txn(input bit ri, input bit ra, input logic [15:0] ci,
                           input logic [15:0] ca, input int done_at,
                           input logic [15:0] rdv, input bit chg, input bit drop,
                           output obs_t o);
    o = '{default: 0};
    o.to_cyc = -1;
    o.done_cyc = -1;
    req_inert = ri; req_a2d = ra; cmd_inert = ci; cmd_a2d = ca;
    tick();
    o.gi = gnt_inert; o.ga = gnt_a2d; o.wrt0 = spi_wrt; o.cmd0 = spi_cmd;
    if (chg) begin cmd_inert = 16'hFFFF; cmd_a2d = 16'hFFFF; end
    if (drop) begin req_inert = 1'b0; req_a2d = 1'b0; end
    for (int c = 1; c <= TO + 4; c++) begin
      tick();
      spi_done = 1'b0;
      if (spi_wrt) o.wrt_extra++;
      if (spi_cmd !== o.cmd0) o.cmd_bad++;
      if (gnt_inert && gnt_a2d) o.multi++;
      if (done_inert && done_a2d) o.multi++;
      if (done_inert || done_a2d) begin
        o.done_cyc = c; o.di = done_inert; o.da = done_a2d;
        o.gnt_done = o.gi ? gnt_inert : gnt_a2d;
        o.rd = rd_data;
        break;
      end
      if (c - 1 == done_at) begin spi_done = 1'b1; spi_rd = rdv; end
      #1;
      if (timeout) begin
        o.to_count++;
        if (o.to_cyc < 0) o.to_cyc = c;
      end
    end
    spi_done = 1'b0;
    req_inert = 1'b0; req_a2d = 1'b0;
    tick();
    o.idle_ok = !gnt_inert && !gnt_a2d && spi_cmd == 16'h0000 && !spi_wrt &&
                !done_inert && !done_a2d && !timeout;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_inert = 0; req_a2d = 0; cmd_inert = 16'h1111; cmd_a2d = 16'h2222;
    spi_done = 0; spi_rd = 16'h0;
    #2;
    compared++; if ({spi_wrt, gnt_inert, gnt_a2d, done_inert, done_a2d, timeout} !== 6'b0) begin mismatched++; $display("FAIL reset_ctrl: got %b expected 000000", {spi_wrt, gnt_inert, gnt_a2d, done_inert, done_a2d, timeout}); end
    compared++; if (spi_cmd !== 16'h0) begin mismatched++; $display("FAIL reset_cmd: got %h expected 0000", spi_cmd); end
    compared++; if (rd_data !== 16'h0) begin mismatched++; $display("FAIL reset_rd: got %h expected 0000", rd_data); end
    tick(); tick();
    rst = 1'b0;
    tick();
    last_a2d = 1'b1; model_rd = 16'h0;
  endtask

  task automatic test_single_inert();
    obs_t o;
    drive_txn(1, 0, 16'hA5A5, 16'h0000, 3, 16'h1234, 0, 0, o);
    compared++; if (o.gi !== 1'b1 || o.ga !== 1'b0) begin mismatched++; $display("FAIL single_gnt: got %b%b expected 10", o.gi, o.ga); end
    compared++; if (o.wrt0 !== 1'b1 || o.wrt_extra != 0) begin mismatched++; $display("FAIL single_wrt: got %b/%0d expected 1/0", o.wrt0, o.wrt_extra); end
    compared++; if (o.cmd0 !== 16'hA5A5) begin mismatched++; $display("FAIL single_cmd: got %h expected a5a5", o.cmd0); end
    compared++; if (o.done_cyc != 5 || o.di !== 1'b1 || o.da !== 1'b0) begin mismatched++; $display("FAIL single_done: got cyc %0d %b%b expected cyc 5 10", o.done_cyc, o.di, o.da); end
    compared++; if (o.rd !== 16'h1234) begin mismatched++; $display("FAIL single_rd: got %h expected 1234", o.rd); end
    compared++; if (o.to_count != 0 || !o.gnt_done || !o.idle_ok) begin mismatched++; $display("FAIL single_misc: got to=%0d gnt=%b idle=%b expected 0 1 1", o.to_count, o.gnt_done, o.idle_ok); end
    last_a2d = 1'b0; model_rd = 16'h1234;
  endtask

  task automatic test_tie();
    obs_t o;
    bit exp_a2d;
    logic [15:0] rdv;
    for (int k = 0; k < 6; k++) begin
      rdv = 16'($urandom);
      exp_a2d = !last_a2d;
      drive_txn(1, 1, 16'h1000 + 16'(k), 16'h2000 + 16'(k), int'($urandom_range(0, 4)), rdv, 0, 0, o);
      compared++; if (o.ga !== exp_a2d || o.gi !== !exp_a2d) begin mismatched++; $display("FAIL tie_gnt[%0d]: got %b%b expected a2d=%b", k, o.gi, o.ga, exp_a2d); end
      compared++; if (o.cmd0 !== (exp_a2d ? 16'h2000 + 16'(k) : 16'h1000 + 16'(k))) begin mismatched++; $display("FAIL tie_cmd[%0d]: got %h", k, o.cmd0); end
      compared++; if (o.da !== exp_a2d || o.di !== !exp_a2d || o.rd !== rdv) begin mismatched++; $display("FAIL tie_done[%0d]: got %b%b rd %h expected a2d=%b rd %h", k, o.di, o.da, o.rd, exp_a2d, rdv); end
      last_a2d = exp_a2d; model_rd = rdv;
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    drive_txn(0, 1, 16'h0F0F, 16'h3C3C, TO + 5, 16'hBEEF, 0, 0, o);
    compared++; if (o.ga !== 1'b1 || o.cmd0 !== 16'h3C3C) begin mismatched++; $display("FAIL to_gnt: got %b %h expected 1 3c3c", o.ga, o.cmd0); end
    compared++; if (o.to_cyc != TO || o.to_count != 1) begin mismatched++; $display("FAIL to_pulse: got cyc %0d count %0d expected cyc %0d count 1", o.to_cyc, o.to_count, TO); end
    compared++; if (o.done_cyc != TO + 1 || o.da !== 1'b1) begin mismatched++; $display("FAIL to_done: got cyc %0d da %b expected cyc %0d da 1", o.done_cyc, o.da, TO + 1); end
    compared++; if (o.rd !== model_rd) begin mismatched++; $display("FAIL to_rd: got %h expected %h", o.rd, model_rd); end
    last_a2d = 1'b1;
  endtask

  task automatic test_collision();
    obs_t o;
    drive_txn(1, 0, 16'h5A5A, 16'h0, TO - 1, 16'hC0DE, 0, 0, o);
    compared++; if (o.to_count != 0) begin mismatched++; $display("FAIL coll_to: got %0d pulses expected 0", o.to_count); end
    compared++; if (o.rd !== 16'hC0DE || o.done_cyc != TO + 1 || o.di !== 1'b1) begin mismatched++; $display("FAIL coll_done: got rd %h cyc %0d expected c0de cyc %0d", o.rd, o.done_cyc, TO + 1); end
    last_a2d = 1'b0; model_rd = 16'hC0DE;
  endtask

  task automatic test_cmd_stability();
    obs_t o;
    drive_txn(1, 0, 16'h6789, 16'h0, 4, 16'h4321, 1, 0, o);
    compared++; if (o.cmd0 !== 16'h6789 || o.cmd_bad != 0) begin mismatched++; $display("FAIL cmd_stable: got %h bad %0d expected 6789 bad 0", o.cmd0, o.cmd_bad); end
    last_a2d = 1'b0; model_rd = 16'h4321;
  endtask

  task automatic test_drop();
    obs_t o;
    drive_txn(0, 1, 16'h0, 16'h9999, 2, 16'h7777, 0, 1, o);
    compared++; if (o.da !== 1'b1 || o.done_cyc != 4 || o.rd !== 16'h7777) begin mismatched++; $display("FAIL drop_done: got da %b cyc %0d rd %h expected 1 4 7777", o.da, o.done_cyc, o.rd); end
    last_a2d = 1'b1; model_rd = 16'h7777;
  endtask

  task automatic test_midop_reset();
    int late_done = 0;
    req_a2d = 1'b1; cmd_a2d = 16'hABCD;
    tick(); tick(); tick();
    req_a2d = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    compared++; if ({spi_wrt, gnt_inert, gnt_a2d, done_inert, done_a2d, timeout} !== 6'b0) begin mismatched++; $display("FAIL midrst_ctrl: got %b expected 000000", {spi_wrt, gnt_inert, gnt_a2d, done_inert, done_a2d, timeout}); end
    compared++; if (spi_cmd !== 16'h0 || rd_data !== 16'h0) begin mismatched++; $display("FAIL midrst_data: got %h/%h expected 0000/0000", spi_cmd, rd_data); end
    tick();
    rst = 1'b0;
    spi_done = 1'b1; spi_rd = 16'hFFFF;
    tick();
    spi_done = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (done_inert || done_a2d || gnt_inert || gnt_a2d || timeout) late_done++;
      tick();
    end
    compared++; if (late_done != 0 || rd_data !== 16'h0) begin mismatched++; $display("FAIL midrst_late: got %0d active cycles rd %h expected 0 0000", late_done, rd_data); end
    last_a2d = 1'b1; model_rd = 16'h0;
  endtask

  task automatic test_random();
    obs_t o;
    bit ri, ra, exp_a2d, chg, drop;
    logic [15:0] ci, ca, rdv, exp_cmd;
    int done_at, exp_done, exp_to;
    for (int k = 0; k < 25; k++) begin
      ri = 1'($urandom); ra = 1'($urandom);
      if (!ri && !ra) ri = 1'b1;
      ci = 16'($urandom); ca = 16'($urandom); rdv = 16'($urandom);
      chg = 1'($urandom); drop = 1'($urandom);
      done_at = int'($urandom_range(0, TO + 1));
      exp_a2d = ra && (!ri || !last_a2d);
      exp_cmd = exp_a2d ? ca : ci;
      if (done_at <= TO - 1) begin
        exp_done = done_at + 2; exp_to = -1; model_rd = rdv;
      end else begin
        exp_done = TO + 1; exp_to = TO;
      end
      drive_txn(ri, ra, ci, ca, done_at, rdv, chg, drop, o);
      compared++; if (o.ga !== exp_a2d || o.gi !== !exp_a2d || o.cmd0 !== exp_cmd || o.wrt0 !== 1'b1) begin mismatched++; $display("FAIL rnd_launch[%0d]: got %b%b %h wrt %b expected a2d=%b %h", k, o.gi, o.ga, o.cmd0, o.wrt0, exp_a2d, exp_cmd); end
      compared++; if (o.done_cyc != exp_done || o.da !== exp_a2d || o.di !== !exp_a2d) begin mismatched++; $display("FAIL rnd_done[%0d]: got cyc %0d %b%b expected cyc %0d a2d=%b", k, o.done_cyc, o.di, o.da, exp_done, exp_a2d); end
      compared++; if (o.to_cyc != exp_to || o.rd !== model_rd) begin mismatched++; $display("FAIL rnd_result[%0d]: got to %0d rd %h expected to %0d rd %h", k, o.to_cyc, o.rd, exp_to, model_rd); end
      compared++; if (o.wrt_extra != 0 || o.cmd_bad != 0 || o.multi != 0 || !o.gnt_done || !o.idle_ok) begin mismatched++; $display("FAIL rnd_hygiene[%0d]: got wrt+%0d cmdbad %0d multi %0d gnt %b idle %b", k, o.wrt_extra, o.cmd_bad, o.multi, o.gnt_done, o.idle_ok); end
      last_a2d = exp_a2d;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_inert();
    test_tie();
    test_timeout();
    test_collision();
    test_cmd_stability();
    test_drop();
    test_midop_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/spi_arb.md
SPI_ARB -- requirements
Module: spi_arb

Interface
- REQ-001 Parameter TIMEOUT_CYC, default 1024: max cycles a granted transaction may wait for spi_done before abort.
- REQ-002 clk  input  1  system clock; all state updates on rising edge.
- REQ-003 rst  input  1  reset, asynchronous, active-high.
- REQ-004 req_inert  input  1  inertial-interface request, level, held until done_inert.
- REQ-005 cmd_inert  input  16  inertial SPI command word.
- REQ-006 req_a2d  input  1  A2D-interface request, level, held until done_a2d.
- REQ-007 cmd_a2d  input  16  A2D SPI command word.
- REQ-008 spi_wrt  output  1  one-cycle launch strobe to the shared SPI master.
- REQ-009 spi_cmd  output  16  command word to the SPI master.
- REQ-010 spi_done  input  1  SPI master transaction-complete pulse.
- REQ-011 spi_rd  input  16  SPI master read data, valid with spi_done.
- REQ-012 gnt_inert / gnt_a2d  output  1 each  level grant, high from capture through FINISH.
- REQ-013 done_inert / done_a2d  output  1 each  one-cycle completion pulse to the owner.
- REQ-014 rd_data  output  16  registered read data returned to the owner.
- REQ-015 timeout  output  1  one-cycle pulse, transaction aborted.

Function
- REQ-016 State machine SHALL have four states: IDLE, LAUNCH, WAIT, FINISH.
- REQ-017 IDLE: no request -> stay; one request -> grant it; both -> grant the requester not served last (round-robin pointer).
- REQ-018 On grant, the owner's cmd SHALL be captured into a 16-bit register, its gnt set, next state LAUNCH.
- REQ-019 Requester cmd changes after capture SHALL have no effect on spi_cmd.
- REQ-020 LAUNCH: spi_wrt=1 for exactly one cycle, spi_cmd=captured word, wait counter cleared, next state WAIT.
- REQ-021 spi_cmd SHALL hold the captured word from LAUNCH through FINISH; 16'h0000 in IDLE.
- REQ-022 WAIT: counter increments each cycle; spi_done=1 -> rd_data<=spi_rd, next FINISH.
- REQ-023 WAIT: counter reaching TIMEOUT_CYC-1 with spi_done=0 -> timeout pulse in that cycle, rd_data unchanged, next FINISH.
- REQ-024 spi_done and timeout condition in the same cycle: spi_done wins, no timeout pulse.
- REQ-025 spi_done in IDLE, LAUNCH or FINISH SHALL be ignored.
- REQ-026 FINISH: owner's done pulse for one cycle, gnt still high; pointer updated to owner; next IDLE with both gnt low.
- REQ-027 Latency: request high in IDLE cycle N -> gnt at N+1, spi_wrt at N+1; spi_done at cycle M -> done_x and rd_data valid at M+1.
- REQ-028 Request still high in IDLE after FINISH SHALL be treated as a new request.
- REQ-029 Requester dropping req while granted SHALL NOT abort the transaction; done pulse still issued.
- REQ-030 At most one gnt and at most one done SHALL be high in any cycle.
- REQ-031 Wait counter SHALL be wide enough for TIMEOUT_CYC-1 and SHALL NOT wrap.

Reset
- REQ-032 rst=1 SHALL immediately force IDLE, counter 0, pointer = "a2d served last" (inertial wins first tie).
- REQ-033 Reset values: spi_wrt=0, spi_cmd=0, gnt_*=0, done_*=0, rd_data=0, timeout=0.
- REQ-034 rst asserted mid-transaction SHALL abort without done or timeout pulse; late spi_done after release is ignored.

Verification
- REQ-035 Single inert: req_inert=1, cmd_inert=16'hA5A5 -> gnt_inert, one spi_wrt with spi_cmd=A5A5; spi_done with spi_rd=16'h1234 -> next cycle done_inert=1, rd_data=1234.
- REQ-036 Tie after reset: both req in same cycle -> inertial first; both held -> a2d next; alternation continues strictly.
- REQ-037 Timeout: TIMEOUT_CYC=8, never drive spi_done -> timeout pulse 8 cycles after spi_wrt, done_a2d next cycle, rd_data unchanged.
- REQ-038 Collision: spi_done in exact timeout cycle -> no timeout pulse, rd_data=spi_rd.
- REQ-039 Mid-op reset: rst during WAIT -> all outputs 0 asynchronously; later spi_done produces no done pulse.
- REQ-040 Cmd stability: change cmd_inert to 16'hFFFF after gnt -> spi_cmd keeps captured value through FINISH.
